// File: rtl/barrel_shifter.sv
// Single-cycle barrel shifter/rotator with a registered result.
// A log2(WIDTH)-stage mux network (stage k moves the word by 2^k when
// shift_amt[k] is set) feeds one output register with a valid strobe and
// a zero flag.
//
// Handshake: in_valid qualifies datain/shift_amt/op in the cycle it is
// high; there is no ready, every qualified operation is accepted and its
// result appears with out_valid high exactly one clock later. Cycles with
// in_valid low leave shifted_data/zero untouched and drop out_valid.
module barrel_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   datain,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic [2:0]         op,
  output logic [WIDTH-1:0]   shifted_data,
  output logic               out_valid,
  output logic               zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // stage[0] is the raw operand, stage[SHAMT_W] the fully shifted word.
  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign stage[0] = datain;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 2 ** k;
    logic [WIDTH-1:0] moved;

    // Move the word by 2^k positions in the direction/fill selected by op;
    // reserved op codes pass the word through untouched.
    always_comb begin
      moved = stage[k];
      case (op)
        OP_SLL: moved = {stage[k][WIDTH-S-1:0], {S{1'b0}}};
        OP_SRL: moved = {{S{1'b0}}, stage[k][WIDTH-1:S]};
        OP_SRA: moved = {{S{stage[k][WIDTH-1]}}, stage[k][WIDTH-1:S]};
        OP_ROL: moved = {stage[k][WIDTH-S-1:0], stage[k][WIDTH-1:WIDTH-S]};
        OP_ROR: moved = {stage[k][S-1:0], stage[k][WIDTH-1:S]};
        default: moved = stage[k];
      endcase
    end

    assign stage[k+1] = shift_amt[k] ? moved : stage[k];
  end

  logic [WIDTH-1:0] shifted_data_d, shifted_data_q;
  logic             out_valid_d, out_valid_q;
  logic             zero_d, zero_q;

  // Next-state: capture the network output on a qualified cycle, else hold.
  always_comb begin
    shifted_data_d = shifted_data_q;
    zero_d         = zero_q;
    out_valid_d    = in_valid;
    if (in_valid) begin
      shifted_data_d = stage[SHAMT_W];
      zero_d         = ~|stage[SHAMT_W];
    end
  end

  // Output register; reset clears the word and flags the empty result as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifted_data_q <= '0;
      out_valid_q    <= 1'b0;
      zero_q         <= 1'b1;
    end else begin
      shifted_data_q <= shifted_data_d;
      out_valid_q    <= out_valid_d;
      zero_q         <= zero_d;
    end
  end

  assign shifted_data = shifted_data_q;
  assign out_valid    = out_valid_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed bench for barrel_shifter at WIDTH=8: reset, each op, boundary
// amounts, zero flag, streaming/hold, and a full operand sweep.
module tb_barrel_shifter;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [WIDTH-1:0]   datain;
  logic [SHAMT_W-1:0] shift_amt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   shifted_data;
  logic               out_valid;
  logic               zero;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];

  barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .datain       (datain),
    .shift_amt    (shift_amt),
    .op           (op),
    .shifted_data (shifted_data),
    .out_valid    (out_valid),
    .zero         (zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference, written as whole-word shifts rather than stages.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] d,
                                                 input logic [SHAMT_W-1:0] a,
                                                 input logic [2:0] o);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0] r;
    int n;
    sd = d;
    n  = int'(a);
    case (o)
      3'd0: r = d << n;
      3'd1: r = d >> n;
      3'd2: r = sd >>> n;
      3'd3: r = (d << n) | (d >> (WIDTH - n));
      3'd4: r = (d >> n) | (d << (WIDTH - n));
      default: r = d;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One qualified op; returns at the falling edge where its result is visible.
  task automatic apply(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] a,
                       input logic [2:0] o);
    @(negedge clk);
    in_valid  = 1'b1;
    datain    = d;
    shift_amt = a;
    op        = o;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'(($urandom_range(0, 1)));
    datain    = 8'($urandom_range(0, 255));
    shift_amt = 3'($urandom_range(0, 7));
    op        = 3'($urandom_range(0, 7));
    repeat (3) @(negedge clk);
    checks++;
    if (shifted_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", shifted_data);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (zero !== 1'b1) begin
      errors++; $display("FAIL reset_zero: got %b expected 1", zero);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops;
    logic [2:0]       ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [WIDTH-1:0] expv [6] = '{8'h98, 8'h16, 8'hF6, 8'h9D, 8'h76, 8'hB3};
    for (int i = 0; i < 6; i++) begin
      apply(8'hB3, 3'd3, ops[i]);
      checks++;
      if (shifted_data !== expv[i]) begin
        errors++;
        $display("FAIL ops_data op=%0d: got %h expected %h", ops[i], shifted_data, expv[i]);
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL ops_valid op=%0d: got %b expected 1", ops[i], out_valid);
      end
    end
  endtask

  task automatic test_boundaries;
    logic [WIDTH-1:0] exp7 [5] = '{8'h80, 8'h01, 8'hFF, 8'hC0, 8'h03};
    for (int o = 0; o < 8; o++) begin
      apply(8'h81, 3'd0, 3'(o));
      checks++;
      if (shifted_data !== 8'h81) begin
        errors++; $display("FAIL amt0 op=%0d: got %h expected 81", o, shifted_data);
      end
    end
    for (int o = 0; o < 5; o++) begin
      apply(8'h81, 3'd7, 3'(o));
      checks++;
      if (shifted_data !== exp7[o]) begin
        errors++; $display("FAIL amt7 op=%0d: got %h expected %h", o, shifted_data, exp7[o]);
      end
    end
  endtask

  task automatic test_zero_flag;
    apply(8'h01, 3'd7, 3'd0);
    checks++;
    if (shifted_data !== 8'h80 || zero !== 1'b0) begin
      errors++; $display("FAIL zero_clear: got %h/%b expected 80/0", shifted_data, zero);
    end
    apply(8'h01, 3'd1, 3'd1);
    checks++;
    if (shifted_data !== 8'h00 || zero !== 1'b1) begin
      errors++; $display("FAIL zero_set: got %h/%b expected 00/1", shifted_data, zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] e;
    exp_q.delete();
    last = 8'h00;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || shifted_data !== e) begin
          errors++;
          $display("FAIL stream[%0d]: got %h valid=%b expected %h valid=1", i - 1, shifted_data, out_valid, e);
        end
        last = e;
      end
      if (i < 10) begin
        in_valid  = 1'b1;
        datain    = 8'($urandom_range(1, 255));
        shift_amt = 3'($urandom_range(0, 7));
        op        = 3'($urandom_range(0, 7));
        exp_q.push_back(ref_model(datain, shift_amt, op));
      end else begin
        in_valid = 1'b0;
        datain   = 8'($urandom_range(0, 255));
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (shifted_data !== last || zero !== (last == 8'h00)) begin
      errors++; $display("FAIL hold_data: got %h/%b expected %h", shifted_data, zero, last);
    end
  endtask

  task automatic test_midstream_reset;
    apply(8'hB3, 3'd0, 3'd7);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (shifted_data !== 8'h00 || out_valid !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %h/%b/%b expected 00/0/1", shifted_data, out_valid, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Launch an op, then reset before its capture edge: it must vanish.
    @(negedge clk);
    in_valid = 1'b1; datain = 8'h5A; shift_amt = 3'd1; op = 3'd3;
    #2 rst_n = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || shifted_data !== 8'h00) begin
      errors++;
      $display("FAIL inflight_discard: got %h valid=%b expected 00 valid=0", shifted_data, out_valid);
    end
  endtask

  task automatic test_sweep;
    logic [WIDTH-1:0] e;
    exp_q.delete();
    for (int d = 0; d < 256; d++) begin
      for (int a = 0; a < 8; a++) begin
        for (int o = 0; o < 8; o++) begin
          @(negedge clk);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || shifted_data !== e || zero !== (e == 8'h00)) begin
              errors++;
              $display("FAIL sweep d=%h a=%0d o=%0d: got %h/%b/%b expected %h", datain, shift_amt, op, shifted_data, out_valid, zero, e);
            end
          end
          in_valid  = 1'b1;
          datain    = 8'(d);
          shift_amt = 3'(a);
          op        = 3'(o);
          exp_q.push_back(ref_model(8'(d), 3'(a), 3'(o)));
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || shifted_data !== e) begin
      errors++; $display("FAIL sweep_last: got %h expected %h", shifted_data, e);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; datain = '0; shift_amt = '0; op = '0;
    test_reset();
    test_ops();
    test_boundaries();
    test_zero_flag();
    test_back_to_back();
    test_midstream_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
